gpio_bank_fpga: RTL and testbench

GPIO_BANK_FPGA -- requirements
Module: gpio_bank_fpga

---
 rtl/gpio_bank_fpga_if.sv | 14 +
 rtl/gpio_bank_fpga.sv | 97 +++++++++
 tb/tb_gpio_bank_fpga.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_bank_fpga_if.sv
// gpio_bank_fpga_if: register-access bus between a host master and the GPIO bank.
interface gpio_bank_fpga_if #(
   parameter int ADDR_W = 7
) ();
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        wdata;
   logic [7:0]        rdata;
   logic              ack;
   logic              irq;
   modport master (output req, we, addr, wdata, input rdata, ack, irq);
   modport slave  (input req, we, addr, wdata, output rdata, ack, irq);
endinterface

// File: rtl/gpio_bank_fpga.sv
// gpio_bank_fpga: byte-port GPIO bank with DIR/OUT/IN/EDGE registers and synchronised inputs.
// Define GPIO_EDGE_IRQ_EN to enable rising-edge capture into EDGE and the level irq.
module gpio_bank_fpga #(
   parameter int PINS_COUNT  = 132,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  CLK50,
   input  logic                  RST_N,
   inout  wire  [PINS_COUNT-1:0] io_pins,
   gpio_bank_fpga_if.slave       bus
);
   localparam int NPORTS = (PINS_COUNT + 7) / 8;
   localparam int ADDR_W = $clog2(NPORTS) + 2;
   localparam int NBITS  = NPORTS * 8;
   localparam logic [NBITS:0]   VM_W  = ~({(NBITS+1){1'b1}} << PINS_COUNT);
   localparam logic [NBITS-1:0] VMASK = VM_W[NBITS-1:0];

   logic [NBITS-1:0] dir_q, dir_d, out_q, out_d, in_w, edge_w;
   logic [SYNC_STAGES-1:0][PINS_COUNT-1:0] sync_q;
   logic [ADDR_W-1:0] a_w;
   logic [7:0] rdata_q, rd_w;
   logic [1:0] sel;
   logic ack_q, acc, wr;
   int p;

   assign a_w       = bus.addr;
   assign in_w      = NBITS'(sync_q[SYNC_STAGES-1]);
   assign bus.ack   = ack_q;
   assign bus.rdata = rdata_q;

   for (genvar i = 0; i < PINS_COUNT; i++) begin : g_pin
      assign io_pins[i] = dir_q[i] ? out_q[i] : 1'bz;
   end

`ifdef GPIO_EDGE_IRQ_EN
   logic [NBITS-1:0] edge_q, edge_d, rise_w;
   // a rise is seen the edge before the last stage takes the new 1
   assign rise_w  = NBITS'(sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1]);
   assign edge_w  = edge_q;
   assign bus.irq = |edge_q;
`else
   assign edge_w  = '0;
   assign bus.irq = 1'b0;
`endif

   always_comb begin
      acc   = bus.req & ~ack_q;
      wr    = acc & bus.we;
      p     = int'(a_w >> 2);
      sel   = a_w[1:0];
      dir_d = dir_q;
      out_d = out_q;
      rd_w  = '0;
`ifdef GPIO_EDGE_IRQ_EN
      edge_d = edge_q;
`endif
      for (int k = 0; k < NPORTS; k++) begin
         if (p == k) begin
            rd_w = sel == 2'd0 ? dir_q[k*8 +: 8] : sel == 2'd1 ? out_q[k*8 +: 8] :
                   sel == 2'd2 ? in_w[k*8 +: 8]  : edge_w[k*8 +: 8];
            if (wr && sel == 2'd0) dir_d[k*8 +: 8] = bus.wdata;
            if (wr && sel == 2'd1) out_d[k*8 +: 8] = bus.wdata;
`ifdef GPIO_EDGE_IRQ_EN
            if (wr && sel == 2'd3) edge_d[k*8 +: 8] = edge_q[k*8 +: 8] & ~bus.wdata;
`endif
         end
      end
      dir_d = dir_d & VMASK;
      out_d = out_d & VMASK;
`ifdef GPIO_EDGE_IRQ_EN
      // new edges override a simultaneous W1C clear
      edge_d = (edge_d | rise_w) & VMASK;
`endif
   end

   always_ff @(posedge CLK50 or negedge RST_N) begin
      if (!RST_N) begin
         dir_q   <= '0;
         out_q   <= '0;
         sync_q  <= '0;
         ack_q   <= 1'b0;
         rdata_q <= '0;
`ifdef GPIO_EDGE_IRQ_EN
         edge_q  <= '0;
`endif
      end else begin
         dir_q   <= dir_d;
         out_q   <= out_d;
         sync_q  <= {sync_q[SYNC_STAGES-2:0], io_pins};
         ack_q   <= acc;
         rdata_q <= (acc & ~bus.we) ? rd_w : 8'h00;
`ifdef GPIO_EDGE_IRQ_EN
         edge_q  <= edge_d;
`endif
      end
   end
endmodule

// File: tb/tb_gpio_bank_fpga.sv
// tb_gpio_bank_fpga: scoreboard bench for gpio_bank_fpga at default parameters.
module tb_gpio_bank_fpga;
   localparam int PINS = 132;
   localparam int SS   = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [PINS-1:0] drv_en  = '0;
   logic [PINS-1:0] drv_val = '0;
   wire  [PINS-1:0] io_pins;
   int n_chk = 0;
   int n_fail = 0;
   logic [7:0] exp_q[$];

   gpio_bank_fpga_if #(.ADDR_W(7)) bus ();

   gpio_bank_fpga #(.PINS_COUNT(PINS), .SYNC_STAGES(SS)) dut (
      .CLK50   (clk),
      .RST_N   (rst_n),
      .io_pins (io_pins),
      .bus     (bus)
   );

   for (genvar g = 0; g < PINS; g++) begin : g_drv
      assign io_pins[g] = drv_en[g] ? drv_val[g] : 1'bz;
   end

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // called just after a falling edge; returns just after a falling edge with ack low
   task automatic access(input bit w, input int a, input logic [7:0] d, input logic [7:0] exp);
      int n;
      logic [7:0] e;
      bus.req = 1'b1; bus.we = w; bus.addr = 7'(a); bus.wdata = d;
      if (!w) exp_q.push_back(exp);
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.ack && n < 4);
      n_chk++;
      if (!bus.ack || n != 1) begin
         n_fail++;
         $display("FAIL ack_latency addr=%0d: ack=%b after %0d cycles, required ack=1 after 1", a, bus.ack, n);
      end
      if (!w) begin
         e = exp_q.pop_front();
         n_chk++;
         if (bus.rdata !== e) begin
            n_fail++;
            $display("FAIL rdata addr=%0d: got %h, required %h", a, bus.rdata, e);
         end
      end
      bus.req = 1'b0;
      @(negedge clk);
      n_chk++;
      if (bus.ack !== 1'b0 || bus.rdata !== 8'h00) begin
         n_fail++;
         $display("FAIL ack_pulse addr=%0d: ack=%b rdata=%h, required ack=0 rdata=00", a, bus.ack, bus.rdata);
      end
   endtask

   task automatic test_reset();
      bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
      rst_n = 1'b0;
      drv_en[7:0] = 8'hFF; drv_val[7:0] = 8'h3C;
      repeat (3) @(negedge clk);
      n_chk++;
      if (bus.ack !== 1'b0 || bus.rdata !== 8'h00 || bus.irq !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: ack=%b rdata=%h irq=%b, required 0/00/0", bus.ack, bus.rdata, bus.irq);
      end
      rst_n = 1'b1;
      access(1'b0, 0, 8'h00, 8'h00);
      repeat (SS) @(negedge clk);
      access(1'b0, 2, 8'h00, 8'h3C);
   endtask

   task automatic test_dir_out();
      access(1'b1, 12, 8'hFF, 8'h00);
      access(1'b1, 13, 8'hA5, 8'h00);
      n_chk++;
      if (io_pins[31:24] !== 8'hA5) begin
         n_fail++;
         $display("FAIL pin_drive: io_pins[31:24]=%h, required a5", io_pins[31:24]);
      end
      access(1'b0, 13, 8'h00, 8'hA5);
      access(1'b0, 12, 8'h00, 8'hFF);
      drv_en[15:8] = 8'hFF; drv_val[15:8] = 8'h00;
      access(1'b1, 5, 8'h55, 8'h00);
      access(1'b0, 5, 8'h00, 8'h55);
   endtask

   task automatic test_in();
      drv_val[9] = 1'b1;
      repeat (SS-1) @(negedge clk);
      access(1'b0, 6, 8'h00, 8'h00);
      access(1'b0, 6, 8'h00, 8'h02);
      access(1'b1, 6, 8'hFF, 8'h00);
      access(1'b0, 6, 8'h00, 8'h02);
   endtask

   task automatic test_last_port();
      access(1'b1, 64, 8'hFF, 8'h00);
      access(1'b0, 64, 8'h00, 8'h0F);
      access(1'b1, 65, 8'hFF, 8'h00);
      access(1'b0, 65, 8'h00, 8'h0F);
      n_chk++;
      if (io_pins[131:128] !== 4'hF) begin
         n_fail++;
         $display("FAIL last_port_pins: io_pins[131:128]=%h, required f", io_pins[131:128]);
      end
      access(1'b1, 80, 8'hFF, 8'h00);
      access(1'b1, 81, 8'hFF, 8'h00);
      access(1'b0, 80, 8'h00, 8'h00);
      access(1'b0, 81, 8'h00, 8'h00);
      access(1'b0, 16, 8'h00, 8'h00);
      access(1'b0, 17, 8'h00, 8'h00);
      access(1'b0, 64, 8'h00, 8'h0F);
   endtask

`ifdef GPIO_EDGE_IRQ_EN
   task automatic test_edge();
      access(1'b1, 3, 8'hFF, 8'h00);
      access(1'b0, 3, 8'h00, 8'h00);
      drv_val[0] = 1'b1;
      repeat (SS+2) @(negedge clk);
      access(1'b0, 3, 8'h00, 8'h01);
      n_chk++;
      if (bus.irq !== 1'b1) begin
         n_fail++;
         $display("FAIL irq_set: irq=%b, required 1", bus.irq);
      end
      access(1'b1, 3, 8'h01, 8'h00);
      n_chk++;
      if (bus.irq !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_clear: irq=%b, required 0", bus.irq);
      end
      drv_val[0] = 1'b0;
      repeat (SS+2) @(negedge clk);
      drv_val[0] = 1'b1;
      repeat (SS-1) @(negedge clk);
      access(1'b1, 3, 8'h01, 8'h00);
      access(1'b0, 3, 8'h00, 8'h01);
   endtask
`else
   task automatic test_edge();
      access(1'b1, 3, 8'hFF, 8'h00);
      access(1'b0, 3, 8'h00, 8'h00);
      n_chk++;
      if (bus.irq !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_tied: irq=%b, required 0", bus.irq);
      end
   endtask
`endif

   task automatic test_back_to_back();
      int acks;
      logic [7:0] e;
      acks = 0;
      bus.req = 1'b1; bus.we = 1'b0; bus.addr = 7'd12; bus.wdata = 8'h00;
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) exp_q.push_back(8'hFF);
         @(negedge clk);
         n_chk++;
         if (bus.ack !== (i % 2 == 0)) begin
            n_fail++;
            $display("FAIL b2b_ack cycle %0d: ack=%b, required %b", i, bus.ack, i % 2 == 0);
         end
         if (bus.ack === 1'b1 && exp_q.size() > 0) begin
            acks++;
            e = exp_q.pop_front();
            n_chk++;
            if (bus.rdata !== e) begin
               n_fail++;
               $display("FAIL b2b_rdata cycle %0d: got %h, required %h", i, bus.rdata, e);
            end
         end
      end
      bus.req = 1'b0;
      exp_q.delete();
      n_chk++;
      if (acks != 3) begin
         n_fail++;
         $display("FAIL b2b_count: %0d ack pulses, required 3", acks);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      bus.req = 1'b1; bus.we = 1'b1; bus.addr = 7'd13; bus.wdata = 8'h3C;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_chk++;
      if (bus.ack !== 1'b0 || bus.rdata !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_mid_ack: ack=%b rdata=%h, required 0/00", bus.ack, bus.rdata);
      end
      bus.req = 1'b0;
      @(negedge clk);
      drv_en[31:24] = 8'hFF; drv_val[31:24] = 8'h5A;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (SS+1) @(negedge clk);
      access(1'b0, 14, 8'h00, 8'h5A);
      access(1'b0, 12, 8'h00, 8'h00);
      access(1'b0, 13, 8'h00, 8'h00);
   endtask

   initial begin
      test_reset();
      test_dir_out();
      test_in();
      test_last_port();
      test_edge();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
